// File: rtl/pd5_pkg.sv
// pd5 core shared definitions.
// Fetch constants, opcode fields, fetch FSM state and F->D bundle.
package pd5_pkg;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          CNT_W    = 32;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } fd_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// F->D pipeline register.
// A bubble keeps the PC but replaces the instruction with a NOP.
module fd_pipe_reg
  import pd5_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic clock,
  input  logic reset,
  input  logic bubble,
  input  fd_t  d,
  output fd_t  q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q.pc    <= '0;
      q.inst  <= BUBBLE_INST;
      q.valid <= 1'b0;
    end else if (bubble) begin
      q.pc    <= d.pc;
      q.inst  <= BUBBLE_INST;
      q.valid <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// pd5 instruction fetch stage with F->D register.
// Drives a 1-cycle synchronous imem; handles stall, redirect, counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = pd5_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = pd5_pkg::NOP_INST,
  parameter int          CNT_W    = pd5_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc_f,
  output logic [31:0]      inst_f,
  output logic [31:0]      pc_d,
  output logic [31:0]      inst_d,
  output logic             valid_d,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pd5_pkg::*;

  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic         fetch_vld_q;
  logic [31:0]  tgt;
  fetch_state_t state;
  fd_t          fd_in;
  fd_t          fd_out;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  assign tgt = word_align(redirect_pc);

  // While stalled the in-flight address is re-read so the
  // data lines up with fetch_pc_q when fetch resumes.
  always_comb begin
    imem_addr = pc_q;
    priority case (1'b1)
      redirect_valid: imem_addr = tgt;
      stall:          imem_addr = fetch_pc_q;
      default:        imem_addr = pc_q;
    endcase
  end

  assign pc_f   = fetch_pc_q;
  assign inst_f = fetch_vld_q ? imem_rdata : NOP_INST;

  assign fd_in.pc    = fetch_pc_q;
  assign fd_in.inst  = inst_f;
  assign fd_in.valid = fetch_vld_q;

  fd_pipe_reg #(
    .BUBBLE_INST(NOP_INST)
  ) u_fd (
    .clock (clock),
    .reset (reset),
    .bubble(redirect_valid | stall),
    .d     (fd_in),
    .q     (fd_out)
  );

  assign pc_d    = fd_out.pc;
  assign inst_d  = fd_out.inst;
  assign valid_d = fd_out.valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      fetch_vld_q  <= 1'b0;
      state        <= BOOT;
      misalign_err <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= tgt + 32'd4;
      fetch_pc_q  <= tgt;
      fetch_vld_q <= 1'b1;
      flush_cnt   <= sat_inc(flush_cnt);
      state       <= RUN;
      if (redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end else if (stall) begin
      state <= HOLD;
      if (state != BOOT)
        stall_cnt <= sat_inc(stall_cnt);
    end else begin
      fetch_pc_q  <= pc_q;
      pc_q        <= pc_q + 32'd4;
      fetch_vld_q <= 1'b1;
      state       <= RUN;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// imem returns address-derived words one cycle after the address.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] inst_f;
  logic [31:0] pc_d;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        misalign_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_f          (pc_f),
    .inst_f        (inst_f),
    .pc_d          (pc_d),
    .inst_d        (inst_d),
    .valid_d       (valid_d),
    .misalign_err  (misalign_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  always @(posedge clock) imem_rdata <= mem(imem_addr);

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    vectors++;
    if (pc_d !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_pc_d: got %h want %h", pc_d, 32'h0);
    end
    vectors++;
    if (inst_d !== NOP) begin
      miscompares++;
      $display("FAIL rst_inst_d: got %h want %h", inst_d, NOP);
    end
    vectors++;
    if (valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid_d: got %b want 0", valid_d);
    end
    vectors++;
    if (pc_f !== RST) begin
      miscompares++;
      $display("FAIL rst_pc_f: got %h want %h", pc_f, RST);
    end
    vectors++;
    if (inst_f !== NOP) begin
      miscompares++;
      $display("FAIL rst_inst_f: got %h want %h", inst_f, NOP);
    end
    vectors++;
    if ({misalign_err, stall_cnt, flush_cnt} !== 65'h0) begin
      miscompares++;
      $display("FAIL rst_status: got %b/%0d/%0d want 0/0/0",
               misalign_err, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    #1;
    vectors++;
    if (imem_addr !== RST) begin
      miscompares++;
      $display("FAIL boot_addr: got %h want %h", imem_addr, RST);
    end
    tick();
    vectors++;
    if (imem_addr !== RST + 4) begin
      miscompares++;
      $display("FAIL c1_addr: got %h want %h", imem_addr, RST + 4);
    end
    vectors++;
    if (inst_f !== mem(RST)) begin
      miscompares++;
      $display("FAIL c1_inst_f: got %h want %h", inst_f, mem(RST));
    end
    vectors++;
    if (valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL c1_valid_d: got %b want 0", valid_d);
    end
    tick();
    vectors++;
    if ({valid_d, pc_d, inst_d} !== {1'b1, RST, mem(RST)}) begin
      miscompares++;
      $display("FAIL c2_fd: got %b %h %h want 1 %h %h",
               valid_d, pc_d, inst_d, RST, mem(RST));
    end
    vectors++;
    if (imem_addr !== RST + 8) begin
      miscompares++;
      $display("FAIL c2_addr: got %h want %h", imem_addr, RST + 8);
    end
    tick();
    vectors++;
    if (pc_f !== RST + 8) begin
      miscompares++;
      $display("FAIL c3_pc_f: got %h want %h", pc_f, RST + 8);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    vectors++;
    if (imem_addr !== RST + 8) begin
      miscompares++;
      $display("FAIL stall_addr0: got %h want %h", imem_addr, RST + 8);
    end
    tick();
    vectors++;
    if ({valid_d, pc_d, inst_d} !== {1'b0, RST + 32'd8, NOP}) begin
      miscompares++;
      $display("FAIL stall_bub1: got %b %h %h want 0 %h %h",
               valid_d, pc_d, inst_d, RST + 8, NOP);
    end
    vectors++;
    if (imem_addr !== RST + 8) begin
      miscompares++;
      $display("FAIL stall_addr1: got %h want %h", imem_addr, RST + 8);
    end
    tick();
    stall = 1'b0;
    #1;
    vectors++;
    if (valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_bub2: got %b want 0", valid_d);
    end
    vectors++;
    if (inst_f !== mem(RST + 8)) begin
      miscompares++;
      $display("FAIL stall_inst_f: got %h want %h", inst_f, mem(RST + 8));
    end
    tick();
    vectors++;
    if ({valid_d, pc_d, inst_d} !== {1'b1, RST + 32'd8, mem(RST + 8)}) begin
      miscompares++;
      $display("FAIL stall_resume: got %b %h %h want 1 %h %h",
               valid_d, pc_d, inst_d, RST + 8, mem(RST + 8));
    end
    vectors++;
    if (stall_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d want 2", stall_cnt);
    end
    vectors++;
    if (inst_f !== mem(RST + 12)) begin
      miscompares++;
      $display("FAIL stall_next: got %h want %h", inst_f, mem(RST + 12));
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0100;
    #1;
    vectors++;
    if (imem_addr !== 32'h0100_0100) begin
      miscompares++;
      $display("FAIL redir_addr: got %h want 01000100", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++;
    if ({pc_f, valid_d} !== {32'h0100_0100, 1'b0}) begin
      miscompares++;
      $display("FAIL redir_f: got %h %b want 01000100 0", pc_f, valid_d);
    end
    vectors++;
    if (flush_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL redir_flush: got %0d want 1", flush_cnt);
    end
    vectors++;
    if (imem_addr !== 32'h0100_0104) begin
      miscompares++;
      $display("FAIL redir_next: got %h want 01000104", imem_addr);
    end
    tick();
    vectors++;
    if ({valid_d, pc_d, inst_d} !==
        {1'b1, 32'h0100_0100, mem(32'h0100_0100)}) begin
      miscompares++;
      $display("FAIL redir_d: got %b %h %h want 1 01000100 %h",
               valid_d, pc_d, inst_d, mem(32'h0100_0100));
    end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0040;
    stall = 1'b1;
    #1;
    vectors++;
    if (imem_addr !== 32'h0100_0040) begin
      miscompares++;
      $display("FAIL rs_addr: got %h want 01000040", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    vectors++;
    if ({pc_f, imem_addr} !== {32'h0100_0040, 32'h0100_0044}) begin
      miscompares++;
      $display("FAIL rs_pc: got %h %h want 01000040 01000044",
               pc_f, imem_addr);
    end
    vectors++;
    if ({stall_cnt, flush_cnt} !== {32'd2, 32'd2}) begin
      miscompares++;
      $display("FAIL rs_cnt: got %0d/%0d want 2/2", stall_cnt, flush_cnt);
    end
    vectors++;
    if (valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL rs_bubble: got %b want 0", valid_d);
    end
  endtask

  task automatic test_misalign();
    vectors++;
    if (misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_pre: got %b want 0", misalign_err);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0102;
    #1;
    vectors++;
    if (imem_addr !== 32'h0100_0100) begin
      miscompares++;
      $display("FAIL mis_addr: got %h want 01000100", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++;
    if ({misalign_err, pc_f} !== {1'b1, 32'h0100_0100}) begin
      miscompares++;
      $display("FAIL mis_set: got %b %h want 1 01000100",
               misalign_err, pc_f);
    end
    vectors++;
    if (flush_cnt !== 32'd3) begin
      miscompares++;
      $display("FAIL mis_flush: got %0d want 3", flush_cnt);
    end
    repeat (2) tick();
    vectors++;
    if (misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_sticky: got %b want 1", misalign_err);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++;
    if ({pc_f, imem_addr} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL wrap_a: got %h %h want fffffff8 fffffffc",
               pc_f, imem_addr);
    end
    tick();
    vectors++;
    if ({pc_f, imem_addr} !== {32'hFFFF_FFFC, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_b: got %h %h want fffffffc 00000000",
               pc_f, imem_addr);
    end
    vectors++;
    if ({valid_d, pc_d, inst_d} !==
        {1'b1, 32'hFFFF_FFF8, mem(32'hFFFF_FFF8)}) begin
      miscompares++;
      $display("FAIL wrap_d: got %b %h %h want 1 fffffff8 %h",
               valid_d, pc_d, inst_d, mem(32'hFFFF_FFF8));
    end
    tick();
    vectors++;
    if ({pc_f, inst_f, misalign_err} !== {32'h0, mem(32'h0), 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_c: got %h %h %b want 00000000 %h 1",
               pc_f, inst_f, misalign_err, mem(32'h0));
    end
  endtask

  task automatic test_reset_hold();
    stall = 1'b1;
    tick();
    tick();
    vectors++;
    if (stall_cnt !== 32'd4) begin
      miscompares++;
      $display("FAIL rh_stall_cnt: got %0d want 4", stall_cnt);
    end
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0200;
    tick();
    vectors++;
    if ({pc_d, inst_d, valid_d} !== {32'h0, NOP, 1'b0}) begin
      miscompares++;
      $display("FAIL rh_fd: got %h %h %b want 00000000 %h 0",
               pc_d, inst_d, valid_d, NOP);
    end
    vectors++;
    if ({pc_f, inst_f} !== {RST, NOP}) begin
      miscompares++;
      $display("FAIL rh_f: got %h %h want %h %h", pc_f, inst_f, RST, NOP);
    end
    vectors++;
    if ({misalign_err, stall_cnt, flush_cnt} !== 65'h0) begin
      miscompares++;
      $display("FAIL rh_status: got %b/%0d/%0d want 0/0/0",
               misalign_err, stall_cnt, flush_cnt);
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    vectors++;
    if (imem_addr !== RST) begin
      miscompares++;
      $display("FAIL rh_addr: got %h want %h", imem_addr, RST);
    end
    tick();
    vectors++;
    if ({pc_f, inst_f, imem_addr} !== {RST, mem(RST), RST + 32'd4}) begin
      miscompares++;
      $display("FAIL rh_refetch: got %h %h %h want %h %h %h",
               pc_f, inst_f, imem_addr, RST, mem(RST), RST + 4);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
